// File: rtl/rv32_div_seq_if.sv
// Start/done handshake bundle between the EX-stage M-extension wrapper and
// the sequential divider.
//   i_start : one-cycle request pulse (wrapper -> divider)
//   i_f3    : funct3 of the DIV/DIVU/REM/REMU instruction
//   i_rs1   : dividend
//   i_rs2   : divisor
//   o_res   : registered result, valid while o_done is high
//   o_done  : level, high from completion until the next accepted start
// Modports: master = wrapper side, slave = divider side.
interface rv32_div_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_start;
    logic [2:0]      i_f3;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic [XLEN-1:0] o_res;
    logic            o_done;

    modport master (
        output i_start, i_f3, i_rs1, i_rs2,
        input  o_res, o_done
    );

    modport slave (
        input  i_start, i_f3, i_rs1, i_rs2,
        output o_res, o_done
    );
endinterface

// File: rtl/rv32_div_seq.sv
// Iterative radix-2 restoring divider for RV32-M DIV/DIVU/REM/REMU.
// One quotient bit per clock over XLEN cycles, then one registered cycle of
// sign fixup. Signed operations divide magnitudes and negate afterwards.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : rv32_div_seq_if slave (i_start, i_f3, i_rs1, i_rs2, o_res, o_done)
// Optional feature macro: ARVI_DIV_ZERO_FASTPATH_EN -- when defined, a zero
// divisor skips the iteration phase and completes one cycle after the start.
module rv32_div_seq #(
    parameter int unsigned XLEN = 32
) (
    input logic           i_clk,
    input logic           i_rst,
    rv32_div_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e          state;
    logic            op_rem;
    logic            quo_neg;
    logic            rem_neg;
    logic [XLEN-1:0] quo;      // holds the dividend, shifted out as quotient bits shift in
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] divisor;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] res;
    logic            done;

    logic            is_signed;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            div_zero;
    logic [XLEN:0]   rem_shift;
    logic            quo_bit;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        is_signed = ~bus.i_f3[0];
        rs1_neg   = is_signed & bus.i_rs1[XLEN-1];
        rs2_neg   = is_signed & bus.i_rs2[XLEN-1];
        rs1_mag   = rs1_neg ? -bus.i_rs1 : bus.i_rs1;
        rs2_mag   = rs2_neg ? -bus.i_rs2 : bus.i_rs2;
        div_zero  = (bus.i_rs2 == '0);

        rem_shift = {rem, quo[XLEN-1]};
        quo_bit   = (rem_shift >= {1'b0, divisor});
        // When the subtract happens the difference is below divisor, so XLEN bits suffice.
        rem_next  = quo_bit ? (rem_shift[XLEN-1:0] - divisor) : rem_shift[XLEN-1:0];

        fix_res   = op_rem ? (rem_neg ? -rem : rem) : (quo_neg ? -quo : quo);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= StIdle;
            op_rem  <= 1'b0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            cnt     <= '0;
            res     <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (bus.i_start) begin
                        op_rem  <= bus.i_f3[1];
                        done    <= 1'b0;
                        rem     <= '0;
                        divisor <= rs2_mag;
                        cnt     <= CW'(XLEN - 1);
                        if (div_zero) begin
                            // Raw dividend and no sign fixup: CALC against zero yields
                            // an all-ones quotient and a remainder equal to rs1.
                            quo_neg <= 1'b0;
                            rem_neg <= 1'b0;
`ifdef ARVI_DIV_ZERO_FASTPATH_EN
                            quo     <= '1;
                            rem     <= bus.i_rs1;
                            state   <= StFix;
`else
                            quo     <= bus.i_rs1;
                            state   <= StCalc;
`endif
                        end else begin
                            quo     <= rs1_mag;
                            quo_neg <= rs1_neg ^ rs2_neg;
                            rem_neg <= rs1_neg;
                            state   <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem <= rem_next;
                    quo <= {quo[XLEN-2:0], quo_bit};
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    res   <= fix_res;
                    done  <= 1'b1;
                    state <= StDone;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.o_res  = res;
    assign bus.o_done = done;
endmodule

// File: doc/rv32_div_seq.md
Name: rv32_div_seq

Overview:
- Iterative radix-2 restoring divider for RV32-M DIV/DIVU/REM/REMU.
- Responder side of the M-extension start/done handshake; instantiated under the EX-stage M-extension wrapper.
- The wrapper issues a one-cycle start pulse and holds the pipeline stalled until done is seen.
- Produces one quotient bit per clock; applies sign fixup in a final registered cycle.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_start  in  1  one-cycle request pulse; operands and f3 are sampled on the same edge.
i_f3  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; only bits [1:0] are decoded.
i_rs1  in  XLEN  dividend.
i_rs2  in  XLEN  divisor.
o_res  out  XLEN  result, registered; valid while o_done=1.
o_done  out  1  level, high in DONE until the next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE, o_done=0, o_res=0, counter=0, and all internal registers cleared. A reset mid-CALC abandons the operation.
- States:
  - IDLE: o_done=0.
  - CALC: XLEN iterations.
  - FIX: sign correction.
  - DONE: o_done=1, o_res held.
- Start acceptance:
  - i_start is accepted only in IDLE or DONE.
  - i_start in CALC or FIX is ignored; the latched operands are not disturbed.
- Start in DONE: o_done falls on the edge after start, and the new operation begins.
- Accept edge E0:
  - Latch f3[1:0].
  - Latch the signed flag (f3[0]=0).
  - Latch quotient sign = signed & (rs1[31]^rs2[31]).
  - Latch remainder sign = signed & rs1[31].
  - Latch |rs1| and |rs2|; magnitudes are used only when signed.
  - Clear the partial remainder and set counter=XLEN-1.
  - Go to CALC.
- CALC, each edge:
  - Shift {rem, quo} left by 1, with the dividend MSB entering rem.
  - If rem_shifted >= divisor: rem = rem_shifted - divisor and the quotient bit = 1; otherwise the bit = 0.
  - Comparison is XLEN+1-bit unsigned.
  - Decrement counter; on counter==0, go to FIX.
- FIX edge:
  - o_res = REM ? (rem sign ? -rem : rem) : (quo sign ? -quo : quo).
  - Go to DONE and set o_done=1.
- Latency: o_done is first high after edge E0+XLEN+1 (33 cycles at XLEN=32).
- Divide by zero (latched divisor==0):
  - Quotient = all ones (0xFFFFFFFF) for DIV and DIVU.
  - Remainder = rs1 unmodified for REM and REMU.
  - Sign fixup is suppressed for both.
- Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, signed): DIV=0x80000000, REM=0.
  - This falls out of the magnitude path: the 32-bit quotient 0x80000000 has positive sign, and the remainder is 0.
- Operands are sampled only at E0. Input changes during CALC/FIX have no effect.
- o_res changes only at the FIX edge or on reset.

Optional Feature:
ARVI_DIV_ZERO_FASTPATH_EN:
- Defined: at E0, a zero divisor skips CALC/FIX.
  - o_res is loaded directly with the div-by-zero result.
  - State goes to DONE and o_done=1 after E0+1.
  - All other cases are unchanged.
- Undefined: div-by-zero runs the full XLEN+1-cycle sequence and produces the same result values.

Test Plan:
- DIVU rs1=100, rs2=7 -> o_done rises exactly 33 cycles after start; o_res=14. REMU on the same operands -> o_res=2.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> o_res=0xFFFFFFFD. REM on the same operands -> o_res=0xFFFFFFFF (-1).
- DIV rs1=5, rs2=0 -> 0xFFFFFFFF. DIV rs1=0xFFFFFFFB, rs2=0 -> 0xFFFFFFFF. REM rs1=0xFFFFFFFB, rs2=0 -> 0xFFFFFFFB. Check latency 33 with the macro off and 1 with it on.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0.
- In CALC: a second i_start with different operands at cycle 10 is ignored, and the result matches the first operation. In DONE: i_start drops o_done next cycle, and the new result is ready after 33 cycles.
- Assert i_rst at cycle 15 of CALC -> o_done=0 and o_res=0 immediately, state=IDLE. A subsequent DIVU 9/3 -> 3.
